nonce_scheduler: RTL and testbench
==================================

# nonce_scheduler

Hash-clock-domain controller between the UART command block and an array of `NUM_CORES` hash cores. It latches each new job (midstate, work data, nonce range) and splits the nonce range into fixed-size chunks. Chunks go to idle cores in rotating-priority order. Golden nonces reported by the cores are serialized into a single pulse/value stream for the UART transmitter.

## Interface
- `NUM_CORES`, 4: number of hash cores served (1–16).
- `CHUNK_LOG2`, 8: chunk size is 2^CHUNK_LOG2 nonces (1–31).

- `hash_clk` in 1: the single clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `new_work` in 1: one-cycle pulse; the job inputs below are valid in that cycle.
- `midstate` in 256, `work_data` in 96, `nonce_min` in 32, `nonce_max` in 32: job fields.
- `core_busy` in NUM_CORES: core is hashing a chunk.
- `core_found` in NUM_CORES: one-cycle pulse; the core found a golden nonce.
- `core_golden_nonce` in 32*NUM_CORES: core i's nonce is at bits [32i+31:32i], valid with `core_found[i]`.
- `core_start` out NUM_CORES: one-hot, one-cycle pulse that starts a chunk.
- `core_nonce_base` out 32, `core_nonce_last` out 32: inclusive chunk bounds, valid while `core_start` ≠ 0.
- `core_midstate` out 256, `core_data` out 96: latched job, held stable until the next `new_work`.
- `core_abort` out 1: one-cycle pulse; all cores drop their current chunk.
- `new_golden_ticket` out 1: one-cycle pulse.
- `golden_nonce` out 32: valid with `new_golden_ticket`, held afterwards.
- `job_done` out 1: one-cycle pulse when the whole range has been hashed.
- `sched_busy` out 1: high in the DISPATCH and DRAIN states.
- `ticket_overflow` out 1: sticky; a ticket was dropped. Cleared only by reset.

## Operation
- States: IDLE, DISPATCH, DRAIN.
- IDLE: wait for `new_work`.
- `new_work` in any state:
  - latch the job and set `next_nonce <= nonce_min`;
  - clear the `issued` mask;
  - if `nonce_min > nonce_max`, go to DRAIN; otherwise go to DISPATCH.
  - In DISPATCH or DRAIN, `core_abort` also pulses in the next cycle.
  - `new_work` takes priority over every other state transition.
- DISPATCH:
  - Core i is eligible when `!core_busy[i] && !issued[i]`.
  - Each cycle, pick the first eligible core at or after `rr_ptr`, wrapping around.
  - For that core, pulse `core_start[i]`, set `issued[i]`, and set `rr_ptr <= i+1` mod NUM_CORES.
  - At most one dispatch per cycle. No eligible core means no dispatch and `rr_ptr` unchanged.
- `issued[i]` clears when `core_busy[i]` is sampled high. A core must raise `core_busy` within 2 cycles of its `core_start`.
- Chunk arithmetic uses 33 bits:
  - `end = next_nonce + 2^CHUNK_LOG2 - 1`;
  - `core_nonce_last = (end > nonce_max) ? nonce_max : end[31:0]`.
  - If `core_nonce_last == nonce_max`, go to DRAIN; otherwise `next_nonce <= core_nonce_last + 1`.
  - `next_nonce` never wraps past 0xFFFFFFFF.
- DRAIN: when `core_busy == 0` and `issued == 0`, pulse `job_done` and go to IDLE.
- Ticket capture and output:
  - `core_found[i]` sets `pend[i]` and captures `nonce_q[i]`.
  - If `pend[i]` is already set and not being drained this cycle, the new ticket is dropped and `ticket_overflow` is set.
  - Each cycle, the lowest pending index k drives `golden_nonce <= nonce_q[k]` and `new_golden_ticket <= 1`, and clears `pend[k]`.
  - Ticket capture and output run independently of the state machine. `new_work` and abort do not clear tickets.
- Reset (`rst_n` low at a clock edge), including mid-job:
  - state IDLE;
  - `rr_ptr`, `issued`, `pend`, `next_nonce` = 0;
  - all outputs 0, including the job registers.
  - No abort pulse is generated.

## Timing
- All outputs are registered.
- `new_work` in cycle n: job outputs valid in cycle n+1. The first `core_start` is no earlier than cycle n+2.
- `core_abort` appears in cycle n+1.
- Dispatch throughput: 1 chunk/cycle when cores are idle.
- `core_found` in cycle n: `new_golden_ticket` no earlier than cycle n+1. Each extra ticket pending ahead of it adds 1 cycle.
- `job_done` comes 1 cycle after the cycle in which DRAIN sees all cores idle.

## Test plan
- Basic range split:
  - Setup: NUM_CORES=4, CHUNK_LOG2=4; `new_work` with min=0, max=63; cores raise busy 1 cycle after start and hold it 20 cycles.
  - Required: starts on cores 0,1,2,3 in consecutive cycles with base/last 0/15, 16/31, 32/47, 48/63; then exactly one `job_done` after the last busy drops.
- Top of range: min=0xFFFFFFF8, max=0xFFFFFFFF → one chunk 0xFFFFFFF8/0xFFFFFFFF, no further `core_start`, `job_done`, no wrap to 0.
- Empty range: min=10, max=5 with cores idle → zero `core_start`, `job_done` pulse 2 cycles after `new_work`.
- Ticket arbitration:
  - Simultaneous `core_found` on cores 1 and 3, nonces 0xAAAA0001 and 0xBBBB0003 → two consecutive pulses carrying 0xAAAA0001 then 0xBBBB0003.
  - A second `core_found[1]` while core 1 is still pending → `ticket_overflow`=1.
- Mid-job replacement: `new_work` during DISPATCH with min=0x1000 → `core_abort` pulse; the next `core_start` carries base 0x1000; no old-job chunk is issued after the `new_work` cycle.
- Reset mid-DISPATCH: `rst_n` low for 1 cycle → all outputs 0 the next cycle, no `core_start` until a new `new_work`.

Source files
------------

// File: rtl/nonce_scheduler.sv
// Hash-domain job scheduler: splits a nonce range into chunks for NUM_CORES hash
// cores and serializes the golden nonces they report into one ticket stream.

module nonce_ticket_slot (
    input  logic        hash_clk,
    input  logic        rst_n,
    input  logic        found,
    input  logic [31:0] nonce,
    input  logic        drain,
    output logic        pend,
    output logic [31:0] nonce_q,
    output logic        drop
);
    // A second ticket can only take the slot if the held one leaves this cycle.
    assign drop = found && pend && !drain;

    always_ff @(posedge hash_clk) begin
        if (!rst_n) begin
            pend    <= 1'b0;
            nonce_q <= '0;
        end else if (found && !drop) begin
            pend    <= 1'b1;
            nonce_q <= nonce;
        end else if (drain) begin
            pend    <= 1'b0;
        end
    end
endmodule

module nonce_scheduler #(
    parameter int NUM_CORES  = 4,
    parameter int CHUNK_LOG2 = 8
) (
    input  logic                    hash_clk,
    input  logic                    rst_n,
    input  logic                    new_work,
    input  logic [255:0]            midstate,
    input  logic [95:0]             work_data,
    input  logic [31:0]             nonce_min,
    input  logic [31:0]             nonce_max,
    input  logic [NUM_CORES-1:0]    core_busy,
    input  logic [NUM_CORES-1:0]    core_found,
    input  logic [32*NUM_CORES-1:0] core_golden_nonce,
    output logic [NUM_CORES-1:0]    core_start,
    output logic [31:0]             core_nonce_base,
    output logic [31:0]             core_nonce_last,
    output logic [255:0]            core_midstate,
    output logic [95:0]             core_data,
    output logic                    core_abort,
    output logic                    new_golden_ticket,
    output logic [31:0]             golden_nonce,
    output logic                    job_done,
    output logic                    sched_busy,
    output logic                    ticket_overflow
);
    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [32:0] CHUNK_M1 = (33'd1 << CHUNK_LOG2) - 33'd1;

    typedef enum logic [1:0] {ST_IDLE, ST_DISPATCH, ST_DRAIN} state_t;

    state_t                        state;
    logic [IDX_W-1:0]              rr_ptr;
    logic [NUM_CORES-1:0]          issued;
    logic [31:0]                   next_nonce;
    logic [31:0]                   job_max;

    logic [NUM_CORES-1:0]          eligible;
    logic                          pick_vld;
    logic [IDX_W-1:0]              pick_idx;
    logic [NUM_CORES-1:0]          start_vec;
    int                            pos;
    logic [32:0]                   chunk_end;
    logic [31:0]                   chunk_last;

    logic [NUM_CORES-1:0]          pend;
    logic [NUM_CORES-1:0][31:0]    nonce_q;
    logic [NUM_CORES-1:0]          drop;
    logic [NUM_CORES-1:0]          drain_vec;
    logic [IDX_W-1:0]              drain_idx;

    // ---------------- ticket slots, one per core ----------------
    assign drain_vec = pend & (~pend + 1'b1);

    always_comb begin
        drain_idx = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--)
            if (pend[i]) drain_idx = IDX_W'(i);
    end

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_slot
        nonce_ticket_slot u_slot (
            .hash_clk (hash_clk),
            .rst_n    (rst_n),
            .found    (core_found[g]),
            .nonce    (core_golden_nonce[32*g +: 32]),
            .drain    (drain_vec[g]),
            .pend     (pend[g]),
            .nonce_q  (nonce_q[g]),
            .drop     (drop[g])
        );
    end

    // ---------------- rotating-priority core pick ----------------
    assign eligible = ~core_busy & ~issued;

    always_comb begin
        pick_vld  = 1'b0;
        pick_idx  = '0;
        pos       = 0;
        start_vec = '0;
        for (int off = 0; off < NUM_CORES; off++) begin
            pos = int'(rr_ptr) + off;
            if (pos >= NUM_CORES) pos = pos - NUM_CORES;
            if (!pick_vld && eligible[pos]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'(pos);
            end
        end
        for (int i = 0; i < NUM_CORES; i++)
            start_vec[i] = pick_vld && (pick_idx == IDX_W'(i));
    end

    // 33-bit end so a chunk near 0xFFFFFFFF clamps instead of wrapping.
    assign chunk_end  = {1'b0, next_nonce} + CHUNK_M1;
    assign chunk_last = (chunk_end > {1'b0, job_max}) ? job_max : chunk_end[31:0];

    // ---------------- state machine and registered outputs ----------------
    always_ff @(posedge hash_clk) begin
        if (!rst_n) begin
            state             <= ST_IDLE;
            rr_ptr            <= '0;
            issued            <= '0;
            next_nonce        <= '0;
            job_max           <= '0;
            core_start        <= '0;
            core_nonce_base   <= '0;
            core_nonce_last   <= '0;
            core_midstate     <= '0;
            core_data         <= '0;
            core_abort        <= 1'b0;
            new_golden_ticket <= 1'b0;
            golden_nonce      <= '0;
            job_done          <= 1'b0;
            sched_busy        <= 1'b0;
            ticket_overflow   <= 1'b0;
        end else begin
            core_start        <= '0;
            core_abort        <= 1'b0;
            job_done          <= 1'b0;
            new_golden_ticket <= |pend;
            if (|pend) golden_nonce <= nonce_q[drain_idx];
            ticket_overflow   <= ticket_overflow | (|drop);
            issued            <= issued & ~core_busy;

            if (new_work) begin
                core_midstate <= midstate;
                core_data     <= work_data;
                job_max       <= nonce_max;
                next_nonce    <= nonce_min;
                issued        <= '0;
                core_abort    <= (state != ST_IDLE);
                sched_busy    <= 1'b1;
                state         <= (nonce_min > nonce_max) ? ST_DRAIN : ST_DISPATCH;
            end else begin
                case (state)
                    ST_DISPATCH: begin
                        if (pick_vld) begin
                            core_start      <= start_vec;
                            core_nonce_base <= next_nonce;
                            core_nonce_last <= chunk_last;
                            issued          <= (issued & ~core_busy) | start_vec;
                            rr_ptr          <= (pick_idx == IDX_W'(NUM_CORES - 1)) ?
                                               '0 : pick_idx + IDX_W'(1);
                            if (chunk_last == job_max) state <= ST_DRAIN;
                            else next_nonce <= chunk_last + 32'd1;
                        end
                    end
                    ST_DRAIN: begin
                        if (core_busy == '0 && issued == '0) begin
                            job_done   <= 1'b1;
                            sched_busy <= 1'b0;
                            state      <= ST_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_nonce_scheduler.sv
// Directed bench for nonce_scheduler: 4 cores, 16-nonce chunks, behavioural core responders.

module tb_nonce_scheduler;
    logic          hash_clk = 1'b0;
    logic          rst_n;
    logic          new_work;
    logic [255:0]  midstate;
    logic [95:0]   work_data;
    logic [31:0]   nonce_min, nonce_max;
    logic [3:0]    core_busy, core_found;
    logic [127:0]  core_golden_nonce;
    logic [3:0]    core_start;
    logic [31:0]   core_nonce_base, core_nonce_last;
    logic [255:0]  core_midstate;
    logic [95:0]   core_data;
    logic          core_abort, new_golden_ticket, job_done, sched_busy, ticket_overflow;
    logic [31:0]   golden_nonce;

    int n_tests = 0;
    int n_fail  = 0;
    int hold_len = 20;
    int cnt [4];

    nonce_scheduler #(.NUM_CORES(4), .CHUNK_LOG2(4)) dut (
        .hash_clk(hash_clk), .rst_n(rst_n), .new_work(new_work),
        .midstate(midstate), .work_data(work_data),
        .nonce_min(nonce_min), .nonce_max(nonce_max),
        .core_busy(core_busy), .core_found(core_found),
        .core_golden_nonce(core_golden_nonce),
        .core_start(core_start), .core_nonce_base(core_nonce_base),
        .core_nonce_last(core_nonce_last), .core_midstate(core_midstate),
        .core_data(core_data), .core_abort(core_abort),
        .new_golden_ticket(new_golden_ticket), .golden_nonce(golden_nonce),
        .job_done(job_done), .sched_busy(sched_busy), .ticket_overflow(ticket_overflow)
    );

    always #5 hash_clk = ~hash_clk;

    // Core responder: busy from the cycle after its start for hold_len cycles.
    always @(posedge hash_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!rst_n || core_abort) cnt[i] <= 0;
            else if (core_start[i])   cnt[i] <= hold_len;
            else if (cnt[i] != 0)     cnt[i] <= cnt[i] - 1;
        end
    end

    always_comb begin
        core_busy = '0;
        for (int i = 0; i < 4; i++) core_busy[i] = (cnt[i] != 0);
    end

    task automatic tick();
        @(posedge hash_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_job(input logic [31:0] mn, input logic [31:0] mx);
        new_work  = 1'b1;
        nonce_min = mn;
        nonce_max = mx;
        tick();
        new_work  = 1'b0;
    endtask

    initial begin
        int starts, dones, aborts, done_at;
        logic [3:0] exp_start;

        rst_n = 1'b0; new_work = 1'b0; core_found = '0; core_golden_nonce = '0;
        midstate = {8{32'h0123_4567}}; work_data = {3{32'h89AB_CDEF}};
        nonce_min = '0; nonce_max = '0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        tick(); tick(); tick();
        rst_n = 1'b1;

        chk("rst_start",    core_start, 0);
        chk("rst_busy",     sched_busy, 0);
        chk("rst_midstate", core_midstate, 0);
        chk("rst_golden",   golden_nonce, 0);
        chk("rst_ovf",      ticket_overflow, 0);
        chk("rst_done",     job_done, 0);

        // basic range split 0..63
        hold_len = 20;
        drive_job(32'd0, 32'd63);
        chk("bas_abort", core_abort, 0);
        chk("bas_mid",   core_midstate, {8{32'h0123_4567}});
        chk("bas_data",  core_data, {3{32'h89AB_CDEF}});
        chk("bas_sbusy", sched_busy, 1);
        chk("bas_nostart", core_start, 0);
        for (int c = 0; c < 4; c++) begin
            tick();
            exp_start = 4'b0001 << c;
            chk("bas_start", core_start, exp_start);
            chk("bas_base",  core_nonce_base, 32'(c * 16));
            chk("bas_last",  core_nonce_last, 32'(c * 16 + 15));
        end
        starts = 0; dones = 0; done_at = -1;
        for (int c = 6; c <= 40; c++) begin
            tick();
            if (core_start != 0) starts++;
            if (job_done) begin dones++; done_at = c; end
        end
        chk("bas_extra",  starts, 0);
        chk("bas_ndone",  dones, 1);
        chk("bas_doneat", done_at, 27);
        chk("bas_idle",   sched_busy, 0);

        // top of range, no wrap
        hold_len = 3;
        drive_job(32'hFFFF_FFF8, 32'hFFFF_FFFF);
        tick();
        chk("top_start", core_start, 4'b0001);
        chk("top_base",  core_nonce_base, 32'hFFFF_FFF8);
        chk("top_last",  core_nonce_last, 32'hFFFF_FFFF);
        starts = 0; dones = 0; done_at = -1;
        for (int c = 3; c <= 20; c++) begin
            tick();
            if (core_start != 0) starts++;
            if (job_done) begin dones++; done_at = c; end
        end
        chk("top_extra",  starts, 0);
        chk("top_ndone",  dones, 1);
        chk("top_doneat", done_at, 7);

        // empty range
        drive_job(32'd10, 32'd5);
        chk("emp_sbusy", sched_busy, 1);
        chk("emp_start1", core_start, 0);
        chk("emp_done1", job_done, 0);
        tick();
        chk("emp_done2", job_done, 1);
        chk("emp_start2", core_start, 0);
        tick();
        chk("emp_done3", job_done, 0);
        chk("emp_idle",  sched_busy, 0);

        // simultaneous tickets on cores 1 and 3
        core_golden_nonce = '0;
        core_golden_nonce[63:32]  = 32'hAAAA_0001;
        core_golden_nonce[127:96] = 32'hBBBB_0003;
        core_found = 4'b1010;
        tick();
        core_found = '0;
        chk("tkt_none", new_golden_ticket, 0);
        tick();
        chk("tkt_v1", new_golden_ticket, 1);
        chk("tkt_n1", golden_nonce, 32'hAAAA_0001);
        tick();
        chk("tkt_v2", new_golden_ticket, 1);
        chk("tkt_n2", golden_nonce, 32'hBBBB_0003);
        tick();
        chk("tkt_v3",   new_golden_ticket, 0);
        chk("tkt_hold", golden_nonce, 32'hBBBB_0003);
        chk("tkt_ovf0", ticket_overflow, 0);

        // overflow: core 1 reports again while still queued behind core 0
        core_golden_nonce[31:0]  = 32'hC0C0_C0C0;
        core_golden_nonce[63:32] = 32'hD1D1_D1D1;
        core_found = 4'b0011;
        tick();
        core_golden_nonce[63:32] = 32'hE1E1_E1E1;
        core_found = 4'b0010;
        tick();
        core_found = '0;
        chk("ovf_v1",  new_golden_ticket, 1);
        chk("ovf_n1",  golden_nonce, 32'hC0C0_C0C0);
        chk("ovf_set", ticket_overflow, 1);
        tick();
        chk("ovf_n2",  golden_nonce, 32'hD1D1_D1D1);
        tick();
        chk("ovf_v3",    new_golden_ticket, 0);
        chk("ovf_stick", ticket_overflow, 1);

        // mid-job replacement
        hold_len = 20;
        drive_job(32'd0, 32'h0000_FFFF);
        tick();
        chk("rep_s1", core_start, 4'b0010);
        chk("rep_b1", core_nonce_base, 32'h0);
        tick();
        chk("rep_s2", core_start, 4'b0100);
        chk("rep_b2", core_nonce_base, 32'h10);
        midstate = {8{32'hFEED_BEEF}};
        drive_job(32'h0000_1000, 32'h0000_1FFF);
        chk("rep_abort", core_abort, 1);
        chk("rep_nost",  core_start, 0);
        chk("rep_mid",   core_midstate, {8{32'hFEED_BEEF}});
        tick();
        chk("rep_abort0", core_abort, 0);
        chk("rep_s3", core_start, 4'b1000);
        chk("rep_b3", core_nonce_base, 32'h1000);
        chk("rep_l3", core_nonce_last, 32'h100F);
        tick();
        chk("rep_s4", core_start, 4'b0001);
        chk("rep_b4", core_nonce_base, 32'h1010);
        chk("rep_l4", core_nonce_last, 32'h101F);

        // reset mid-dispatch
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst_start", core_start, 0);
        chk("mrst_abort", core_abort, 0);
        chk("mrst_mid",   core_midstate, 0);
        chk("mrst_data",  core_data, 0);
        chk("mrst_base",  core_nonce_base, 0);
        chk("mrst_last",  core_nonce_last, 0);
        chk("mrst_gold",  golden_nonce, 0);
        chk("mrst_ovf",   ticket_overflow, 0);
        chk("mrst_sbusy", sched_busy, 0);
        starts = 0; aborts = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (core_start != 0) starts++;
            if (core_abort) aborts++;
        end
        chk("mrst_nostart", starts, 0);
        chk("mrst_noabort", aborts, 0);
        drive_job(32'd0, 32'd15);
        tick();
        chk("post_start", core_start, 4'b0001);
        chk("post_base",  core_nonce_base, 32'h0);
        chk("post_last",  core_nonce_last, 32'hF);
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
